// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, RISC-V funct3 codes and master FSM states.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR2} ahb_m_state_t;

    // Access is misaligned when the low address bits do not fit the size.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

    // Replicate store data over every lane so the slave picks its own bytes.
    function automatic logic [31:0] lane_rep(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   lane_rep = {4{wd[7:0]}};
            2'b01:   lane_rep = {2{wd[15:0]}};
            default: lane_rep = wd;
        endcase
    endfunction
endpackage

// File: rtl/ahb_lite_mem_master_if.sv
// AHB-Lite bus bundle between the memory master and its slave.
interface ahb_lite_mem_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );
    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed load lane from a bus word and sign/zero-extends it.
module load_extend
    import ahb_pkg::*;
(
    input  logic [2:0]  fn3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ext
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane pick then extension; fn3[2] selects unsigned.
    always_comb begin
        case (addr_lo)
            2'b00:   byte_v = rdata[7:0];
            2'b01:   byte_v = rdata[15:8];
            2'b10:   byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (fn3[1:0])
            2'b00:   ext = fn3[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   ext = fn3[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: ext = rdata;
        endcase
    end
endmodule

// File: rtl/ahb_lite_mem_master.sv
// Single-request load/store port to AHB-Lite SINGLE transfers.
module ahb_lite_mem_master
    import ahb_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL        = 4'b0011,
    parameter bit         RESP_ON_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [2:0]  fn3,
    output logic [31:0] mem_out,
    output logic        mem_done,
    output logic        mem_err,
    output logic        mem_busy,
    ahb_lite_mem_master_if.master bus
);
    ahb_m_state_t state_q;
    logic [31:0]  haddr_q, hwdata_q, wdata_q, mem_out_q, ext;
    logic [1:0]   htrans_q;
    logic [2:0]   hsize_q, fn3_q;
    logic         hwrite_q, done_q, err_q, busy_q;
    logic         mis;
    logic [31:0]  addr_al;

    assign mis     = misaligned(fn3[1:0], address[1:0]);
    assign addr_al = (fn3[1:0] == 2'b00) ? address :
                     (fn3[1:0] == 2'b01) ? {address[31:1], 1'b0} :
                                           {address[31:2], 2'b00};

    load_extend u_ext (
        .fn3    (fn3_q),
        .addr_lo(haddr_q[1:0]),
        .rdata  (bus.HRDATA),
        .ext    (ext)
    );

    // Request FSM; all bus and core outputs are registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            haddr_q   <= '0;
            htrans_q  <= HTRANS_IDLE;
            hwrite_q  <= 1'b0;
            hsize_q   <= '0;
            hwdata_q  <= '0;
            wdata_q   <= '0;
            fn3_q     <= '0;
            mem_out_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (mem_en) begin
                    if (!(mem_read ^ mem_write) || (RESP_ON_MISALIGN && mis)) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
                        haddr_q  <= RESP_ON_MISALIGN ? address : addr_al;
                        htrans_q <= HTRANS_NONSEQ;
                        hwrite_q <= mem_write;
                        hsize_q  <= {1'b0, fn3[1:0]};
                        fn3_q    <= fn3;
                        wdata_q  <= lane_rep(fn3[1:0], wdata);
                        busy_q   <= 1'b1;
                        state_q  <= S_ADDR;
                    end
                end
                S_ADDR: if (bus.HREADY) begin
                    htrans_q <= HTRANS_IDLE;
                    hwdata_q <= wdata_q;
                    state_q  <= S_DATA;
                end
                S_DATA: begin
                    if (bus.HREADY) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                        if (bus.HRESP == HRESP_ERROR) err_q <= 1'b1;
                        else if (!hwrite_q)           mem_out_q <= ext;
                    end else if (bus.HRESP == HRESP_ERROR) begin
                        state_q <= S_ERR2;
                    end
                end
                default: if (bus.HREADY) begin
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.HADDR  = haddr_q;
    assign bus.HTRANS = htrans_q;
    assign bus.HWRITE = hwrite_q;
    assign bus.HSIZE  = hsize_q;
    assign bus.HBURST = HBURST_SINGLE;
    assign bus.HPROT  = HPROT_VAL;
    assign bus.HWDATA = hwdata_q;
    assign mem_out    = mem_out_q;
    assign mem_done   = done_q;
    assign mem_err    = err_q;
    assign mem_busy   = busy_q;
endmodule

// File: tb/tb_ahb_lite_mem_master.sv
// Directed bench: bench acts as the AHB slave cycle by cycle.
module tb_ahb_lite_mem_master;
    logic        clk = 1'b0;
    logic        reset, mem_en, mem_read, mem_write;
    logic [31:0] address, wdata, mem_out;
    logic [2:0]  fn3;
    logic        mem_done, mem_err, mem_busy;
    int          n_chk = 0, n_pass = 0;

    ahb_lite_mem_master_if bus();

    ahb_lite_mem_master dut (
        .clk(clk), .reset(reset), .mem_en(mem_en), .mem_read(mem_read),
        .mem_write(mem_write), .address(address), .wdata(wdata), .fn3(fn3),
        .mem_out(mem_out), .mem_done(mem_done), .mem_err(mem_err),
        .mem_busy(mem_busy), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
        mem_en = 1'b1; mem_read = rd; mem_write = wr;
        address = a; wdata = wd; fn3 = f3;
        step();
        mem_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        reset = 1'b0; mem_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = '0; wdata = '0; fn3 = '0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
        step(); step();
        chk("rst_htrans", {30'b0, bus.HTRANS}, 32'h0);
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_out", mem_out, 32'h0);
        chk("rst_flags", {29'b0, mem_done, mem_err, mem_busy}, 32'h0);
        chk("rst_burst_prot", {25'b0, bus.HBURST, bus.HPROT}, 32'h3);
        reset = 1'b1;
        step();

        // LW, zero wait
        bus.HRDATA = 32'hDEADBEEF;
        req(1, 0, 32'h100, 0, 3'b010);
        chk("lw_htrans", {30'b0, bus.HTRANS}, 32'h2);
        chk("lw_haddr", bus.HADDR, 32'h100);
        chk("lw_hsize", {29'b0, bus.HSIZE}, 32'h2);
        chk("lw_busy", {30'b0, mem_busy, mem_done}, 32'h2);
        step();
        chk("lw_dphase", {29'b0, bus.HTRANS, mem_done}, 32'h0);
        step();
        chk("lw_done", {30'b0, mem_done, mem_err}, 32'h2);
        chk("lw_out", mem_out, 32'hDEADBEEF);
        chk("lw_busy_low", {31'b0, mem_busy}, 32'h0);
        step();
        chk("lw_pulse", {31'b0, mem_done}, 32'h0);

        // LB / LBU lane 3, LH upper half
        bus.HRDATA = 32'h80112233;
        req(1, 0, 32'h203, 0, 3'b000);
        chk("lb_hsize", {29'b0, bus.HSIZE}, 32'h0);
        step(); step();
        chk("lb_out", mem_out, 32'hFFFFFF80);
        req(1, 0, 32'h203, 0, 3'b100);
        step(); step();
        chk("lbu_out", mem_out, 32'h00000080);
        req(1, 0, 32'h206, 0, 3'b001);
        step(); step();
        chk("lh_out", mem_out, 32'hFFFF8011);
        req(1, 0, 32'h206, 0, 3'b101);
        step(); step();
        chk("lhu_out", mem_out, 32'h00008011);

        // SH with two data-phase wait states
        req(0, 1, 32'h302, 32'h0000ABCD, 3'b001);
        chk("sh_addr", {bus.HADDR[27:0], bus.HSIZE, bus.HWRITE}, {28'h302, 3'b001, 1'b1});
        step();
        chk("sh_hwdata", bus.HWDATA, 32'hABCDABCD);
        bus.HREADY = 1'b0;
        step();
        chk("sh_wait1", {bus.HWDATA[30:0], mem_done}, {31'h2BCDABCD, 1'b0});
        step();
        chk("sh_wait2", {bus.HWDATA[30:0], mem_done}, {31'h2BCDABCD, 1'b0});
        bus.HREADY = 1'b1;
        step();
        chk("sh_done", {30'b0, mem_done, mem_err}, 32'h2);
        chk("sh_out_kept", mem_out, 32'h00008011);

        // Two-cycle ERROR response
        bus.HRDATA = 32'h55555555;
        req(1, 0, 32'h400, 0, 3'b010);
        step();
        bus.HREADY = 1'b0; bus.HRESP = 1'b1;
        step();
        chk("err_first", {31'b0, mem_done}, 32'h0);
        bus.HREADY = 1'b1;
        step();
        bus.HRESP = 1'b0;
        chk("err_done", {30'b0, mem_done, mem_err}, 32'h3);
        chk("err_out_kept", mem_out, 32'h00008011);
        chk("err_busy", {31'b0, mem_busy}, 32'h0);

        // Misaligned LW, then illegal read+write
        req(1, 0, 32'h102, 0, 3'b010);
        chk("mis_done", {29'b0, bus.HTRANS, mem_done}, 32'h1);
        chk("mis_err", {30'b0, mem_err, mem_busy}, 32'h2);
        step();
        chk("mis_after", {29'b0, bus.HTRANS, mem_done}, 32'h0);
        req(1, 1, 32'h100, 0, 3'b010);
        chk("both_err", {29'b0, mem_done, mem_err, bus.HTRANS[1]}, 32'h6);

        // Reset during a stalled address phase
        bus.HREADY = 1'b0;
        req(1, 0, 32'h500, 0, 3'b010);
        step();
        chk("stall_hold", {bus.HADDR[29:0], bus.HTRANS}, {30'h500, 2'b10});
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.HREADY = 1'b1;
        chk("mrst_bus", {bus.HADDR[29:0], bus.HTRANS}, 32'h0);
        chk("mrst_flags", {29'b0, mem_done, mem_err, mem_busy}, 32'h0);
        chk("mrst_out", mem_out, 32'h0);
        bus.HRDATA = 32'h12345678;
        req(1, 0, 32'h104, 0, 3'b010);
        chk("post_htrans", {30'b0, bus.HTRANS}, 32'h2);
        step(); step();
        chk("post_done", {30'b0, mem_done, mem_err}, 32'h2);
        chk("post_out", mem_out, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
